// File: rtl/tt_um_marxkar_seqgen.sv
// Serial pattern transmitter tile.
// Loads a 1..PAT_W-bit pattern and shifts it out MSB-first on uo_out[0], one
// bit per enabled clock. It can send a single frame or repeat frames with a
// programmable idle gap. Standard TT user-tile port wrapper.
module tt_um_marxkar_seqgen #(
   parameter int PAT_W = 8,
   parameter int GAP   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int LEN_W = $clog2(PAT_W);
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((GAP > 0) ? GAP - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SEND = 2'd1,
      S_GAP  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   // Control fields from ui_in.
   logic             start_in;
   logic             rpt_in;
   logic [LEN_W-1:0] len_in;
   logic             load_in;
   logic             abort_in;
   logic             start_edge;

   assign start_in = ui_in[0];
   assign rpt_in   = ui_in[1];
   assign len_in   = ui_in[2 +: LEN_W];
   assign load_in  = ui_in[5];
   assign abort_in = ui_in[6];

   // ui_in[7] carries no function in this tile.
   logic unused_ok;
   assign unused_ok = ui_in[7];

   state_t           state_q,     state_d;
   logic [PAT_W-1:0] pat_q,       pat_d;
   logic [LEN_W-1:0] len_q,       len_d;
   logic [LEN_W-1:0] idx_q,       idx_d;
   logic [GAP_W-1:0] gapcnt_q,    gapcnt_d;
   logic             start_dly_q, start_dly_d;

   assign start_edge = start_in & ~start_dly_q;

   // Next-state logic: abort beats load/start, which beat normal progression.
   // NOTE: every signal assigned here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      state_d     = state_q;
      pat_d       = pat_q;
      len_d       = len_q;
      idx_d       = idx_q;
      gapcnt_d    = gapcnt_q;
      start_dly_d = start_in;

      if (abort_in) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (load_in) begin
                  pat_d = uio_in[PAT_W-1:0];
                  len_d = len_in;
               end
               if (start_edge) begin
                  state_d = S_SEND;
                  idx_d   = load_in ? len_in : len_q;
               end
            end
            S_SEND: begin
               if (idx_q == '0) begin
                  if (rpt_in) begin
                     if (GAP > 0) begin
                        state_d  = S_GAP;
                        gapcnt_d = GAP_INIT;
                     end else begin
                        idx_d = len_q;
                     end
                  end else begin
                     state_d = S_DONE;
                  end
               end else begin
                  idx_d = idx_q - LEN_W'(1);
               end
            end
            S_GAP: begin
               if (gapcnt_q == '0) begin
                  state_d = S_SEND;
                  idx_d   = len_q;
               end else begin
                  gapcnt_d = gapcnt_q - GAP_W'(1);
               end
            end
            S_DONE: begin
               state_d = S_IDLE;
            end
            default: begin
               state_d = S_IDLE;
            end
         endcase
      end
   end

   // State register: async reset, updates only on enabled edges.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         pat_q       <= '0;
         len_q       <= '0;
         idx_q       <= '0;
         gapcnt_q    <= '0;
         start_dly_q <= 1'b0;
      end else if (ena) begin
         state_q     <= state_d;
         pat_q       <= pat_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         gapcnt_q    <= gapcnt_d;
         start_dly_q <= start_dly_d;
      end
   end

   // Output decode from registers only; no ui_in path reaches uo_out.
   logic       sending;
   logic       sdo;
   logic       busy;
   logic       done;
   logic [2:0] idx_out;

   assign sending = (state_q == S_SEND);
   assign sdo     = sending & pat_q[idx_q];
   assign busy    = (state_q != S_IDLE);
   assign done    = (state_q == S_DONE);
   assign idx_out = sending ? 3'(idx_q) : 3'd0;

   assign uo_out  = {1'b0, idx_out, done, busy, sending, sdo};
   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_marxkar_seqgen.sv
// Directed testbench for tt_um_marxkar_seqgen (PAT_W=8, GAP=2).
// uo_out byte = {0, idx[2:0], done, busy, valid, sdo}.
module tb_tt_um_marxkar_seqgen;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   logic       start;
   logic       rpt;
   logic [2:0] len_f;
   logic       load;
   logic       abort;

   int n_pass  = 0;
   int n_total = 0;

   assign ui_in = {1'b0, abort, load, len_f, rpt, start};

   tt_um_marxkar_seqgen #(.PAT_W(8), .GAP(2)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Advance one clock; outputs are then read 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected byte while sending bit i of pattern pat.
   function automatic logic [7:0] send_byte(input logic [7:0] pat, input int i);
      return {1'b0, 3'(i), 1'b0, 1'b1, 1'b1, pat[i]};
   endfunction

   task automatic test_reset();
      rst_n = 1'b0; ena = 1'b1; uio_in = 8'h00;
      start = 0; rpt = 0; len_f = 0; load = 0; abort = 0;
      tick(); tick();
      n_total++;
      if (uo_out !== 8'h00) $display("FAIL reset_hold: uo_out=%02h expected 00", uo_out);
      else n_pass++;
      rst_n = 1'b1;
      tick();
      n_total++;
      if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h00)
         $display("FAIL reset_release: uo_out=%02h uio_out=%02h uio_oe=%02h expected 00/00/00",
                  uo_out, uio_out, uio_oe);
      else n_pass++;
   endtask

   task automatic test_single();
      logic [7:0] exp [6] = '{8'h37, 8'h26, 8'h17, 8'h07, 8'h0C, 8'h00};
      uio_in = 8'h0B; len_f = 3'd3; load = 1; start = 0;
      tick();
      load = 0;
      n_total++;
      if (uo_out !== 8'h00) $display("FAIL single_load_only: uo_out=%02h expected 00", uo_out);
      else n_pass++;
      start = 1;
      tick();
      for (int c = 0; c < 6; c++) begin
         n_total++;
         if (uo_out !== exp[c])
            $display("FAIL single cyc%0d: uo_out=%02h expected %02h", c + 1, uo_out, exp[c]);
         else n_pass++;
         start = 0;
         tick();
      end
   endtask

   task automatic test_repeat();
      logic [7:0] exp [12] = '{8'h37, 8'h26, 8'h17, 8'h07, 8'h04, 8'h04,
                               8'h37, 8'h26, 8'h17, 8'h07, 8'h0C, 8'h00};
      rpt = 1; start = 1;
      tick();
      for (int c = 0; c < 12; c++) begin
         n_total++;
         if (uo_out !== exp[c])
            $display("FAIL repeat cyc%0d: uo_out=%02h expected %02h", c + 1, uo_out, exp[c]);
         else n_pass++;
         start = 0;
         if (c == 7) rpt = 0;
         tick();
      end
   endtask

   task automatic test_lengths();
      uio_in = 8'hA5; len_f = 3'd7; load = 1;
      tick();
      load = 0; start = 1;
      tick();
      for (int i = 7; i >= 0; i--) begin
         n_total++;
         if (uo_out !== send_byte(8'hA5, i))
            $display("FAIL len8 bit%0d: uo_out=%02h expected %02h", i, uo_out, send_byte(8'hA5, i));
         else n_pass++;
         start = 0;
         tick();
      end
      n_total++;
      if (uo_out !== 8'h0C) $display("FAIL len8_done: uo_out=%02h expected 0C", uo_out);
      else n_pass++;
      tick();
      // Single-bit frame, loaded in the same cycle as the start edge.
      uio_in = 8'h01; len_f = 3'd0; load = 1; start = 1;
      tick();
      load = 0; start = 0;
      n_total++;
      if (uo_out !== 8'h07) $display("FAIL len1_bit: uo_out=%02h expected 07", uo_out);
      else n_pass++;
      tick();
      n_total++;
      if (uo_out !== 8'h0C) $display("FAIL len1_done: uo_out=%02h expected 0C", uo_out);
      else n_pass++;
      tick();
      n_total++;
      if (uo_out !== 8'h00) $display("FAIL len1_idle: uo_out=%02h expected 00", uo_out);
      else n_pass++;
   endtask

   task automatic test_abort();
      uio_in = 8'h0B; len_f = 3'd3; load = 1;
      tick();
      load = 0; start = 1;
      tick();
      start = 0;
      n_total++;
      if (uo_out !== 8'h37) $display("FAIL abort_bit1: uo_out=%02h expected 37", uo_out);
      else n_pass++;
      tick();
      n_total++;
      if (uo_out !== 8'h26) $display("FAIL abort_bit2: uo_out=%02h expected 26", uo_out);
      else n_pass++;
      abort = 1;
      tick();
      abort = 0;
      n_total++;
      if (uo_out !== 8'h00) $display("FAIL abort_next: uo_out=%02h expected 00", uo_out);
      else n_pass++;
      tick();
      n_total++;
      if (uo_out !== 8'h00) $display("FAIL abort_no_done: uo_out=%02h expected 00", uo_out);
      else n_pass++;
      start = 1;
      tick();
      for (int i = 3; i >= 0; i--) begin
         n_total++;
         if (uo_out !== send_byte(8'h0B, i))
            $display("FAIL abort_replay bit%0d: uo_out=%02h expected %02h", i, uo_out, send_byte(8'h0B, i));
         else n_pass++;
         start = 0;
         tick();
      end
      n_total++;
      if (uo_out !== 8'h0C) $display("FAIL abort_replay_done: uo_out=%02h expected 0C", uo_out);
      else n_pass++;
      tick();
   endtask

   task automatic test_ena_hold();
      start = 1;
      tick();
      start = 0;
      n_total++;
      if (uo_out !== 8'h37) $display("FAIL ena_bit1: uo_out=%02h expected 37", uo_out);
      else n_pass++;
      tick();
      ena = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_total++;
         if (uo_out !== 8'h26)
            $display("FAIL ena_frozen cyc%0d: uo_out=%02h expected 26", c, uo_out);
         else n_pass++;
      end
      ena = 1;
      tick();
      for (int i = 1; i >= 0; i--) begin
         n_total++;
         if (uo_out !== send_byte(8'h0B, i))
            $display("FAIL ena_resume bit%0d: uo_out=%02h expected %02h", i, uo_out, send_byte(8'h0B, i));
         else n_pass++;
         tick();
      end
      n_total++;
      if (uo_out !== 8'h0C) $display("FAIL ena_done: uo_out=%02h expected 0C", uo_out);
      else n_pass++;
      tick();
   endtask

   task automatic test_load_in_send_and_held_start();
      start = 1;
      tick();
      for (int i = 3; i >= 0; i--) begin
         n_total++;
         if (uo_out !== send_byte(8'h0B, i))
            $display("FAIL held bit%0d: uo_out=%02h expected %02h", i, uo_out, send_byte(8'h0B, i));
         else n_pass++;
         // Attempt a load while SEND is in progress; it must be ignored.
         uio_in = 8'hFF; len_f = 3'd7; load = (i != 0);
         tick();
      end
      load = 0;
      n_total++;
      if (uo_out !== 8'h0C) $display("FAIL held_done: uo_out=%02h expected 0C", uo_out);
      else n_pass++;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_total++;
         if (uo_out !== 8'h00) $display("FAIL held_no_retrigger cyc%0d: uo_out=%02h expected 00", c, uo_out);
         else n_pass++;
      end
      start = 0; len_f = 3'd3;
      tick();
      start = 1;
      tick();
      start = 0;
      for (int i = 3; i >= 0; i--) begin
         n_total++;
         if (uo_out !== send_byte(8'h0B, i))
            $display("FAIL load_ignored bit%0d: uo_out=%02h expected %02h", i, uo_out, send_byte(8'h0B, i));
         else n_pass++;
         tick();
      end
      tick();
   endtask

   task automatic test_reset_mid_frame();
      start = 1;
      tick();
      start = 0;
      tick();
      n_total++;
      if (uo_out !== 8'h26) $display("FAIL rst_mid_pre: uo_out=%02h expected 26", uo_out);
      else n_pass++;
      rst_n = 0;
      #2;
      n_total++;
      if (uo_out !== 8'h00) $display("FAIL rst_mid_async: uo_out=%02h expected 00", uo_out);
      else n_pass++;
      #1;
      rst_n = 1;
      tick();
      n_total++;
      if (uo_out !== 8'h00) $display("FAIL rst_mid_after1: uo_out=%02h expected 00", uo_out);
      else n_pass++;
      tick();
      n_total++;
      if (uo_out !== 8'h00) $display("FAIL rst_mid_after2: uo_out=%02h expected 00", uo_out);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_single();
      test_repeat();
      test_lengths();
      test_abort();
      test_ena_hold();
      test_load_in_send_and_held_start();
      test_reset_mid_frame();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
